pump_drive_sequencer: RTL
=========================

Name: pump_drive_sequencer

Overview:
- Actuator-side partner of the water-level controller. Consumes the combinational `pump` request plus the underground-tank interlock, and produces the registered motor-enable drive.
- Enforces anti-short-cycle timing (minimum on and minimum off) and dry-run cut-off.
- Checks for flow after start and while running. On flow failure it latches a fault until software or the operator clears it.
- Sits between the level controller and the motor contactor driver.

Parameters:
- MIN_ON_CYC, 32, minimum cycles motor_en stays high once asserted (unless overridden by the interlock or a fault).
- MIN_OFF_CYC, 16, cycles motor_en is held low in HOLD after any stop.
- FLOW_TIMEOUT, 8, cycles without flow_ok tolerated in PRIME (after start) or RUN (consecutive) before declaring FAULT.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- pump  in  1  run request from level controller (1 = run)
- ug_ll  in  1  underground tank water present (0 = dry, stop immediately)
- flow_ok  in  1  flow sensor, 1 = water moving, synchronous to clk
- fault_clr  in  1  single-cycle pulse; clears a latched fault
- motor_en  out  1  motor contactor drive
- running  out  1  1 while in RUN (flow confirmed)
- fault  out  1  latched flow fault
- state  out  3  state code: IDLE=0, PRIME=1, RUN=2, HOLD=3, FAULT=4

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, motor_en=0, running=0, fault=0, all counters 0. Reset mid-operation drops motor_en on that same edge.
- Outputs are Moore, decoded from the registered state:
  - motor_en=1 only in PRIME and RUN.
  - running=1 only in RUN.
  - fault=1 only in FAULT.
- on_cnt:
  - Cleared on entry to PRIME.
  - Increments every cycle in PRIME/RUN, saturating at MIN_ON_CYC.
  - "min_on_met" means on_cnt ≥ MIN_ON_CYC−1 at the sampling edge, so motor_en is high ≥ MIN_ON_CYC cycles.
- tcnt: a shared timer, cleared on every state entry and on every cycle flow_ok=1 in RUN. Width $clog2 of the largest parameter plus 1.
- Priority in PRIME/RUN: ug_ll=0 > flow timeout > pump=0.
- IDLE:
  - pump=1 and ug_ll=1 → PRIME. motor_en rises one cycle after the request is sampled.
  - Otherwise stay in IDLE.
- PRIME:
  - ug_ll=0 → HOLD.
  - Else flow_ok=1 → RUN.
  - Else tcnt==FLOW_TIMEOUT−1 → FAULT. motor_en is therefore high exactly FLOW_TIMEOUT cycles when flow never appears.
  - Else pump=0 and min_on_met → HOLD.
  - Otherwise stay in PRIME.
- RUN:
  - ug_ll=0 → HOLD. This overrides min-on.
  - Else flow_ok=0 for FLOW_TIMEOUT consecutive cycles (tcnt==FLOW_TIMEOUT−1 with flow_ok=0) → FAULT. Any flow_ok=1 clears tcnt.
  - Else pump=0 and min_on_met → HOLD.
  - pump=0 before min_on_met is held off: the block stays in RUN and stops on the first edge at which min_on_met is true, provided pump is still 0.
- HOLD:
  - motor_en=0.
  - After exactly MIN_OFF_CYC cycles → IDLE. All inputs are ignored meanwhile, including pump re-assertion.
  - Earliest restart: motor_en low ≥ MIN_OFF_CYC+1 cycles between runs.
- FAULT:
  - motor_en=0, fault=1. pump and ug_ll are ignored.
  - fault_clr=1 → HOLD, so off time is still enforced.
  - fault_clr outside FAULT has no effect.
- Simultaneous events:
  - ug_ll=0 together with a timeout → HOLD, no fault.
  - flow_ok=1 on the timeout edge in PRIME → RUN.
  - fault_clr together with pump=1 → HOLD, not PRIME.
- Unused state codes 5–7 → IDLE on the next edge, with outputs 0.

Test Plan (defaults MIN_ON=32, MIN_OFF=16, FLOW_TIMEOUT=8):
1. Reset and start:
   - rst_n=0 for 3 edges with pump=1, ug_ll=1 → motor_en=0, fault=0, state=0 throughout.
   - Release → state=1 and motor_en=1 one edge later.
2. Normal cycle and min-on:
   - flow_ok rises 3 cycles into PRIME → state=2, running=1.
   - pump=0 at on-cycle 5 → motor_en stays high for exactly 32 cycles total.
   - Then state=3 with motor_en=0 for 16 cycles, then state=0.
3. No flow:
   - flow_ok held 0 → motor_en high exactly 8 cycles, then state=4, fault=1.
   - pump toggling has no effect.
   - fault_clr pulse → state=3 for 16 cycles, then state=0, fault=0.
4. Dry run:
   - In RUN at on-cycle 10, ug_ll→0 → motor_en=0 on the next edge, state=3, fault=0.
   - Simultaneous timeout edge → still HOLD.
5. Flow glitch tolerance:
   - In RUN, flow_ok=0 for 7 cycles then 1 → no fault, running stays 1.
   - Later flow_ok=0 for 8 cycles → state=4 and motor_en=0 on the 8th edge.
6. Short-cycle and reset mid-run:
   - pump re-asserted on HOLD cycle 2 → motor_en stays 0 until HOLD completes, then PRIME one edge after IDLE.
   - rst_n=0 during RUN → motor_en=0, state=0 at that edge.

Source files
------------

// File: rtl/pump_drive_sequencer.sv
// pump_drive_sequencer: registered motor-enable drive with min on/off timing, dry-run cut-off and latched flow fault.
module pump_drive_sequencer #(
    parameter int MIN_ON_CYC   = 32,
    parameter int MIN_OFF_CYC  = 16,
    parameter int FLOW_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pump,
    input  logic       ug_ll,
    input  logic       flow_ok,
    input  logic       fault_clr,
    output logic       motor_en,
    output logic       running,
    output logic       fault,
    output logic [2:0] state
);
    localparam int MAX_AB = (MIN_ON_CYC > MIN_OFF_CYC) ? MIN_ON_CYC : MIN_OFF_CYC;
    localparam int MAXP   = (MAX_AB > FLOW_TIMEOUT) ? MAX_AB : FLOW_TIMEOUT;
    localparam int CW     = $clog2(MAXP) + 1;
    localparam logic [CW-1:0] ON_MAX   = CW'(MIN_ON_CYC);
    localparam logic [CW-1:0] ON_LAST  = CW'(MIN_ON_CYC - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(MIN_OFF_CYC - 1);
    localparam logic [CW-1:0] FT_LAST  = CW'(FLOW_TIMEOUT - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        RUN   = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t        cur, nxt;
    logic [CW-1:0] tcnt, on_cnt;
    logic          min_on_met;

    assign min_on_met = on_cnt >= ON_LAST;

    always_comb begin
        nxt = IDLE;
        case (cur)
            IDLE:    nxt = (pump && ug_ll) ? PRIME : IDLE;
            PRIME:   nxt = !ug_ll ? HOLD : flow_ok ? RUN : (tcnt == FT_LAST) ? FAULT :
                           (!pump && min_on_met) ? HOLD : PRIME;
            RUN:     nxt = !ug_ll ? HOLD : (!flow_ok && tcnt == FT_LAST) ? FAULT :
                           (!pump && min_on_met) ? HOLD : RUN;
            HOLD:    nxt = (tcnt == OFF_LAST) ? IDLE : HOLD;
            FAULT:   nxt = fault_clr ? HOLD : FAULT;
            default: nxt = IDLE;
        endcase
    end

    // tcnt restarts on every state change and on each flow-confirmed RUN cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur    <= IDLE;
            tcnt   <= '0;
            on_cnt <= '0;
        end else begin
            cur    <= nxt;
            tcnt   <= (nxt != cur || (cur == RUN && flow_ok)) ? '0 :
                      (tcnt == '1) ? tcnt : tcnt + ONE;
            on_cnt <= (nxt == PRIME && cur != PRIME) ? '0 :
                      ((cur == PRIME || cur == RUN) && on_cnt != ON_MAX) ? on_cnt + ONE : on_cnt;
        end
    end

    assign motor_en = (cur == PRIME) || (cur == RUN);
    assign running  = cur == RUN;
    assign fault    = cur == FAULT;
    assign state    = cur;
endmodule
